// File: rtl/dcls_error_manager_if.sv
// Register-window bus between the SoC control interconnect and the DCLS error manager.
// The master drives strobes, address and write data; the slave returns registered read data.
interface dcls_error_manager_if;
    logic        reg_wr_i;
    logic        reg_rd_i;
    logic [3:0]  reg_addr_i;
    logic [31:0] reg_wdata_i;
    logic [31:0] reg_rdata_o;

    modport master (
        output reg_wr_i,
        output reg_rd_i,
        output reg_addr_i,
        output reg_wdata_i,
        input  reg_rdata_o
    );

    modport slave (
        input  reg_wr_i,
        input  reg_rd_i,
        input  reg_addr_i,
        input  reg_wdata_i,
        output reg_rdata_o
    );
endinterface

// File: rtl/dcls_error_manager.sv
// DCLS error manager: latches comparator error episodes into sticky status, counts them,
// raises an interrupt and sequences the comparator clear, by software ACK or auto core reset.
module dcls_error_manager #(
    parameter int ERR_CNT_W    = 16,
    parameter int RESET_CYCLES = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 dcls_comparator_error_0_i,
    input  logic                 dcls_comparator_error_1_i,
    input  logic [31:0]          dcls_comparator_error_vector_0_i,
    input  logic [31:0]          dcls_comparator_error_vector_1_i,
    output logic                 dcls_comparator_clear_0_o,
    output logic                 dcls_comparator_clear_1_o,
    output logic                 irq_o,
    output logic                 core_reset_req_o,
    dcls_error_manager_if.slave  reg_if
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LATCHED = 2'd1,
        ST_RESET   = 2'd2,
        ST_CLEAR   = 2'd3
    } state_e;

    localparam logic [7:0] RST_LAST = 8'(RESET_CYCLES - 1);

    state_e                 state_q;
    logic [1:0]             clr_phase_q;
    logic [7:0]             rst_cnt_q;
    logic                   clear_q, core_reset_q, irq_q, irq_d;
    logic                   err0_q, err0_d, err1_q, err1_d, dis_q, dis_d;
    logic [31:0]            vector_q, vector_d;
    logic [ERR_CNT_W-1:0]   count_q, count_d, count_base_s;
    logic                   irq_en_q, irq_en_d, auto_q, auto_d;
    logic [31:0]            rdata_q, rdata_s;
    logic                   wr_count_s, wr_ctrl_s, ack_s, err_any_s, capture_s, accum_s;
    logic                   unused_s;

    assign unused_s = ^{dcls_comparator_error_vector_1_i, reg_if.reg_addr_i[1:0],
                        reg_if.reg_wdata_i[30:2]};

    assign wr_count_s = reg_if.reg_wr_i && (reg_if.reg_addr_i[3:2] == 2'd2);
    assign wr_ctrl_s  = reg_if.reg_wr_i && (reg_if.reg_addr_i[3:2] == 2'd3);
    assign ack_s      = wr_ctrl_s && reg_if.reg_wdata_i[31];
    assign err_any_s  = dcls_comparator_error_0_i | dcls_comparator_error_1_i;
    assign capture_s  = (state_q == ST_IDLE) && err_any_s;
    assign accum_s    = (state_q == ST_LATCHED);

    // Next-state of status, counter and control; new errors take priority over an ACK clear.
    always_comb begin
        err0_d = (ack_s ? 1'b0 : err0_q) | ((capture_s | accum_s) & dcls_comparator_error_0_i);
        err1_d = (ack_s ? 1'b0 : err1_q) | ((capture_s | accum_s) & dcls_comparator_error_1_i);
        dis_d  = (ack_s ? 1'b0 : dis_q)
               | (dcls_comparator_error_0_i ^ dcls_comparator_error_1_i);
        if (capture_s) begin
            vector_d = dcls_comparator_error_vector_0_i;
        end else if (accum_s) begin
            vector_d = (ack_s ? 32'd0 : vector_q) | dcls_comparator_error_vector_0_i;
        end else begin
            vector_d = ack_s ? 32'd0 : vector_q;
        end
        count_base_s = wr_count_s ? '0 : count_q;
        if (capture_s && (count_base_s != '1)) begin
            count_d = count_base_s + 1'b1;
        end else begin
            count_d = count_base_s;
        end
        irq_en_d = wr_ctrl_s ? reg_if.reg_wdata_i[0] : irq_en_q;
        auto_d   = wr_ctrl_s ? reg_if.reg_wdata_i[1] : auto_q;
        irq_d    = irq_en_d & (err0_d | err1_d | dis_d);
    end

    // Register status, counter, control and the interrupt output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            dis_q    <= 1'b0;
            vector_q <= 32'd0;
            count_q  <= '0;
            irq_en_q <= 1'b0;
            auto_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            dis_q    <= dis_d;
            vector_q <= vector_d;
            count_q  <= count_d;
            irq_en_q <= irq_en_d;
            auto_q   <= auto_d;
            irq_q    <= irq_d;
        end
    end

    // Episode FSM; CLEAR walks entry, clear pulse, then a settle cycle before IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            clr_phase_q  <= 2'd0;
            rst_cnt_q    <= 8'd0;
            clear_q      <= 1'b0;
            core_reset_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (err_any_s) begin
                        state_q <= ST_LATCHED;
                    end
                end
                ST_LATCHED: begin
                    if (auto_q) begin
                        state_q      <= ST_RESET;
                        core_reset_q <= 1'b1;
                        rst_cnt_q    <= RST_LAST;
                    end else if (ack_s) begin
                        state_q     <= ST_CLEAR;
                        clr_phase_q <= 2'd0;
                    end
                end
                ST_RESET: begin
                    if (rst_cnt_q == 8'd0) begin
                        core_reset_q <= 1'b0;
                        state_q      <= ST_CLEAR;
                        clr_phase_q  <= 2'd0;
                    end else begin
                        rst_cnt_q <= rst_cnt_q - 8'd1;
                    end
                end
                ST_CLEAR: begin
                    case (clr_phase_q)
                        2'd0: begin
                            clear_q     <= 1'b1;
                            clr_phase_q <= 2'd1;
                        end
                        2'd1: begin
                            clear_q     <= 1'b0;
                            clr_phase_q <= 2'd2;
                        end
                        default: begin
                            clear_q     <= 1'b0;
                            clr_phase_q <= 2'd0;
                            state_q     <= ST_IDLE;
                        end
                    endcase
                end
                default: begin
                    state_q      <= ST_IDLE;
                    clear_q      <= 1'b0;
                    core_reset_q <= 1'b0;
                end
            endcase
        end
    end

    // Read mux over the current (pre-write) register values.
    always_comb begin
        case (reg_if.reg_addr_i[3:2])
            2'd0:    rdata_s = {26'd0, state_q, 1'b0, dis_q, err1_q, err0_q};
            2'd1:    rdata_s = vector_q;
            2'd2:    rdata_s = 32'(count_q);
            2'd3:    rdata_s = {30'd0, auto_q, irq_en_q};
            default: rdata_s = 32'd0;
        endcase
    end

    // Read data register holds until the next read strobe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= 32'd0;
        end else if (reg_if.reg_rd_i) begin
            rdata_q <= rdata_s;
        end
    end

    assign reg_if.reg_rdata_o        = rdata_q;
    assign dcls_comparator_clear_0_o = clear_q;
    assign dcls_comparator_clear_1_o = clear_q;
    assign core_reset_req_o          = core_reset_q;
    assign irq_o                     = irq_q;
endmodule

// File: tb/tb_dcls_error_manager.sv
// Directed bench for dcls_error_manager; the counter is built 4 bits wide so saturation
// is reachable with a handful of episodes.
module tb_dcls_error_manager;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        e0, e1;
    logic [31:0] v0, v1;
    logic        c0, c1, irq, crr;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    dcls_error_manager_if bus ();

    dcls_error_manager #(.ERR_CNT_W(4), .RESET_CYCLES(8)) dut (
        .clk_i                            (clk),
        .rst_ni                           (rst_n),
        .dcls_comparator_error_0_i        (e0),
        .dcls_comparator_error_1_i        (e1),
        .dcls_comparator_error_vector_0_i (v0),
        .dcls_comparator_error_vector_1_i (v1),
        .dcls_comparator_clear_0_o        (c0),
        .dcls_comparator_clear_1_o        (c1),
        .irq_o                            (irq),
        .core_reset_req_o                 (crr),
        .reg_if                           (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [3:0] addr, input logic [31:0] data);
        bus.reg_wr_i    = 1'b1;
        bus.reg_addr_i  = addr;
        bus.reg_wdata_i = data;
        tick();
        bus.reg_wr_i = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        bus.reg_rd_i   = 1'b1;
        bus.reg_addr_i = addr;
        tick();
        bus.reg_rd_i = 1'b0;
        check_eq(tag, bus.reg_rdata_o, exp);
    endtask

    task automatic err_pulse(input logic a, input logic b, input logic [31:0] vec);
        e0 = a; e1 = b; v0 = vec;
        tick();
        e0 = 1'b0; e1 = 1'b0; v0 = 32'd0;
    endtask

    task automatic ack_episode();
        reg_write(4'hC, 32'h8000_0000);
        repeat (3) tick();
    endtask

    initial begin
        int rst_hi, clr0_hi, clr1_hi, clr_at;
        rst_n = 1'b0; e0 = 1'b0; e1 = 1'b0; v0 = 32'd0; v1 = 32'd0;
        bus.reg_wr_i = 1'b0; bus.reg_rd_i = 1'b0; bus.reg_addr_i = 4'd0; bus.reg_wdata_i = 32'd0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        check_eq("rst_crr", {31'd0, crr}, 32'd0);
        check_eq("rst_clr", {30'd0, c1, c0}, 32'd0);
        check_eq("rst_rdata", bus.reg_rdata_o, 32'd0);
        read_check("rst_status", 4'h0, 32'd0);
        read_check("rst_vector", 4'h4, 32'd0);
        read_check("rst_count", 4'h8, 32'd0);
        read_check("rst_ctrl", 4'hC, 32'd0);

        // Software ACK path with interrupt
        reg_write(4'hC, 32'h0000_0001);
        err_pulse(1'b1, 1'b1, 32'h0000_0005);
        check_eq("ack_irq_hi", {31'd0, irq}, 32'd1);
        read_check("ack_status", 4'h0, 32'h13);
        read_check("ack_vector", 4'h4, 32'h5);
        read_check("ack_count", 4'h8, 32'h1);
        reg_write(4'hC, 32'h8000_0001);
        check_eq("ack_irq_lo", {31'd0, irq}, 32'd0);
        check_eq("ack_clr_n", {30'd0, c1, c0}, 32'd0);
        tick();
        check_eq("ack_clr_n1", {30'd0, c1, c0}, 32'd3);
        tick();
        check_eq("ack_clr_n2", {30'd0, c1, c0}, 32'd0);
        tick();
        read_check("ack_idle", 4'h0, 32'h00);
        read_check("ack_ctrl", 4'hC, 32'h1);

        // Automatic core-reset path
        reg_write(4'h8, 32'd0);
        reg_write(4'hC, 32'h0000_0002);
        err_pulse(1'b1, 1'b1, 32'h0000_000A);
        check_eq("auto_crr_latched", {31'd0, crr}, 32'd0);
        rst_hi = 0; clr0_hi = 0; clr1_hi = 0; clr_at = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (crr) rst_hi++;
            if (c0) begin clr0_hi++; clr_at = i; end
            if (c1) clr1_hi++;
        end
        check_eq("auto_rst_cycles", rst_hi, 32'd8);
        check_eq("auto_clr0", clr0_hi, 32'd1);
        check_eq("auto_clr1", clr1_hi, 32'd1);
        check_eq("auto_clr_at", clr_at, 32'd9);
        check_eq("auto_irq", {31'd0, irq}, 32'd0);
        read_check("auto_status", 4'h0, 32'h03);
        read_check("auto_count", 4'h8, 32'h1);
        read_check("auto_vector", 4'h4, 32'hA);
        reg_write(4'hC, 32'h8000_0000);
        read_check("idle_ack_status", 4'h0, 32'h00);

        // Channel disagreement
        err_pulse(1'b1, 1'b0, 32'd0);
        read_check("dis_status", 4'h0, 32'h15);
        ack_episode();
        read_check("dis_count", 4'h8, 32'h2);

        // COUNT write with simultaneous capture, then accumulation in LATCHED
        bus.reg_wr_i = 1'b1; bus.reg_addr_i = 4'h8; bus.reg_wdata_i = 32'hFFFF_FFFF;
        e0 = 1'b1; e1 = 1'b1; v0 = 32'h0000_0001;
        tick();
        bus.reg_wr_i = 1'b0; v0 = 32'h0000_0100;
        tick();
        e0 = 1'b0; e1 = 1'b0; v0 = 32'd0;
        read_check("acc_vector", 4'h4, 32'h101);
        read_check("acc_count", 4'h8, 32'h1);
        read_check("acc_status", 4'h0, 32'h13);
        ack_episode();

        // ACK and new error in the same IDLE cycle: capture wins
        bus.reg_wr_i = 1'b1; bus.reg_addr_i = 4'hC; bus.reg_wdata_i = 32'h8000_0000;
        e1 = 1'b1; v0 = 32'h0000_0040;
        tick();
        bus.reg_wr_i = 1'b0; e1 = 1'b0; v0 = 32'd0;
        read_check("ackcap_status", 4'h0, 32'h16);
        read_check("ackcap_vector", 4'h4, 32'h40);
        read_check("ackcap_count", 4'h8, 32'h2);
        ack_episode();

        // Counter saturation at all-ones (4-bit build)
        reg_write(4'h8, 32'd0);
        for (int i = 0; i < 17; i++) begin
            err_pulse(1'b1, 1'b1, 32'd0);
            ack_episode();
            if (i == 14) read_check("sat_count_15", 4'h8, 32'hF);
        end
        read_check("sat_count_17", 4'h8, 32'hF);
        reg_write(4'h8, 32'h1234_5678);
        read_check("count_wr_clear", 4'h8, 32'h0);

        // Asynchronous reset during RESET state
        reg_write(4'hC, 32'h0000_0002);
        err_pulse(1'b1, 1'b1, 32'd0);
        repeat (2) tick();
        check_eq("mid_crr_hi", {31'd0, crr}, 32'd1);
        read_check("mid_status", 4'h0, 32'h23);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_crr_drop", {31'd0, crr}, 32'd0);
        check_eq("mid_rdata_zero", bus.reg_rdata_o, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        read_check("post_rst_status", 4'h0, 32'h00);
        read_check("post_rst_ctrl", 4'hC, 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dcls_error_manager.md
# dcls_error_manager

Responder to the DCLS comparator: samples the comparator's per-cycle error flags and vectors, latches them into sticky status, counts error episodes, raises an interrupt, and drives the comparator clear inputs once an episode is acknowledged by software or by an automatic core-reset sequence. It sits beside the comparator in the DCLS wrapper and exposes a small register window to the SoC control bus.

## Interface
- ERR_CNT_W, 16: width of the saturating episode counter.
- RESET_CYCLES, 8: cycles core_reset_req_o is held in auto-recovery; legal range 1..255.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- dcls_comparator_error_0_i / _1_i  in  1 each  redundant error flags from the comparator.
- dcls_comparator_error_vector_0_i / _1_i  in  32 each  per-signal mismatch vectors.
- dcls_comparator_clear_0_o / _1_o  out  1 each  clear requests to the comparator.
- reg_wr_i, reg_rd_i  in  1 each  single-cycle write/read strobes.
- reg_addr_i  in  4  byte address; bits [3:2] select the register.
- reg_wdata_i  in  32  write data.
- reg_rdata_o  out  32  read data, registered.
- irq_o  out  1  error interrupt.
- core_reset_req_o  out  1  reset request to both cores.

## Operation
- Registers:
  - 0x0 STATUS (RO): [0] err0_sticky, [1] err1_sticky, [2] chan_disagree, [5:4] FSM state code.
  - 0x4 VECTOR (RO): OR of vector_0_i over the current episode.
  - 0x8 COUNT (RW): episode count; any write clears it to 0.
  - 0xC CTRL (RW): [0] irq_en, [1] auto_reset_en; write with [31]=1 is an ACK pulse (bit 31 reads 0).
- chan_disagree sets on any cycle where error_0_i != error_1_i, in any state.
- FSM:
  - IDLE (code 0): on error_0_i|error_1_i go to LATCHED, load VECTOR from vector_0_i, set sticky bits, increment COUNT saturating at all-ones.
  - LATCHED (code 1): keep OR-ing vector_0_i into VECTOR and setting sticky bits. If auto_reset_en=1 go to RESET; else wait for ACK, then go to CLEAR.
  - RESET (code 2): core_reset_req_o=1 for exactly RESET_CYCLES cycles, then CLEAR.
  - CLEAR (code 3): clear_0_o=clear_1_o=1 for exactly one cycle, then go to IDLE after one settle cycle with clears low. Errors in the settle cycle are ignored because the comparator output is not yet updated.
- ACK in any state clears err0/err1_sticky, chan_disagree and VECTOR. ACK in IDLE/RESET/CLEAR causes no transition.
- irq_o = irq_en & (err0_sticky | err1_sticky | chan_disagree).
- Reads of unmapped bits return 0. reg_rd_i and reg_wr_i in the same cycle: the read returns the pre-write value.

## Timing
- Reset values: all registers 0, FSM IDLE, reg_rdata_o=0, irq_o=0, clear_0_o=clear_1_o=0, core_reset_req_o=0.
- Error at edge N (IDLE) gives state LATCHED, sticky set and COUNT+1 after edge N. irq_o is high in the same cycle if irq_en=1.
- ACK written at edge N (LATCHED) gives clears high during cycle N+1, low at N+2, and IDLE at N+3.
- Auto path: RESET entered at edge N+1 after latch, core_reset_req_o high for RESET_CYCLES cycles, then CLEAR.
- reg_rdata_o is valid the cycle after reg_rd_i and holds until the next read.
- ACK and a new error in the same IDLE cycle: the capture wins, so sticky and VECTOR hold the new error.
- COUNT write and increment in the same cycle: COUNT=1.
- rst_ni low mid-episode: immediate return to reset values. core_reset_req_o and the clears drop asynchronously.

## Test plan
- Reset, then read all four registers: each returns 0; irq_o=0.
- CTRL=0x1; pulse error_0=error_1=1 with vector_0=0x0000_0005 for 1 cycle: STATUS=0x13, VECTOR=0x5, COUNT=1, irq_o=1. Write CTRL=0x8000_0001: one-cycle clear pulse, STATUS=0x00 after 3 cycles, irq_o=0.
- CTRL=0x2, RESET_CYCLES=8; raise an error: core_reset_req_o high exactly 8 cycles, then a 1-cycle clear, then IDLE. COUNT=1; sticky bits remain set.
- error_0=1, error_1=0 for one cycle: chan_disagree=1 and an episode starts.
- Preload COUNT=0xFFFF via 0xFFFF episodes (or a forced value): one further episode leaves 0xFFFF. A write to COUNT reads back 0.
- Hold errors in the LATCHED state with vectors 0x1 then 0x100: VECTOR=0x101 and COUNT increments only once.
- Assert rst_ni low during RESET: core_reset_req_o drops immediately and the state reads IDLE.
